// File: rtl/median9_pkg.sv
// median9_pkg: definitions shared by the 3x3 median filter core.
//   DATA_W          : default pixel width in bits (unsigned pixels)
//   MEDIAN9_LATENCY : number of register stages from window input to pixel_out
//   pixel_t         : one pixel at the default width
package median9_pkg;

  localparam int DATA_W          = 8;
  localparam int MEDIAN9_LATENCY = 3;

  typedef logic [DATA_W-1:0] pixel_t;

endpackage : median9_pkg

// File: rtl/median9_sort_if.sv
// median9_sort_if: pixel bus between the window generator and the median core.
//   pixel_in0..pixel_in8 : 3x3 window, row-major (0..2 top, 3..5 middle, 6..8 bottom)
//   pixel_out            : registered median of the window presented 3 cycles earlier
//   in_valid / out_valid : present only when MEDIAN9_VALID_EN is defined
// Modports: master drives the window (producer side), slave is the median core.
interface median9_sort_if #(
  parameter int DATA_W = median9_pkg::DATA_W
);

  logic [DATA_W-1:0] pixel_in0;
  logic [DATA_W-1:0] pixel_in1;
  logic [DATA_W-1:0] pixel_in2;
  logic [DATA_W-1:0] pixel_in3;
  logic [DATA_W-1:0] pixel_in4;
  logic [DATA_W-1:0] pixel_in5;
  logic [DATA_W-1:0] pixel_in6;
  logic [DATA_W-1:0] pixel_in7;
  logic [DATA_W-1:0] pixel_in8;
  logic [DATA_W-1:0] pixel_out;
`ifdef MEDIAN9_VALID_EN
  logic              in_valid;
  logic              out_valid;
`endif

`ifdef MEDIAN9_VALID_EN
  modport master (
    output pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4,
           pixel_in5, pixel_in6, pixel_in7, pixel_in8, in_valid,
    input  pixel_out, out_valid
  );
  modport slave (
    input  pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4,
           pixel_in5, pixel_in6, pixel_in7, pixel_in8, in_valid,
    output pixel_out, out_valid
  );
`else
  modport master (
    output pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4,
           pixel_in5, pixel_in6, pixel_in7, pixel_in8,
    input  pixel_out
  );
  modport slave (
    input  pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4,
           pixel_in5, pixel_in6, pixel_in7, pixel_in8,
    output pixel_out
  );
`endif

endinterface : median9_sort_if

// File: rtl/median9_sort_sort3.sv
// sort3: combinational three-input ascending sorter.
//   a, b, c : unsigned inputs
//   lo      : smallest, mid : middle (doubles as median3), hi : largest
// Three compare-exchange steps; ties may swap, which never changes the values.
module sort3 #(
  parameter int DATA_W = median9_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] mid,
  output logic [DATA_W-1:0] hi
);

  logic [DATA_W-1:0] ab_lo_s;
  logic [DATA_W-1:0] ab_hi_s;
  logic [DATA_W-1:0] bc_lo_s;

  // order a/b, then push the larger against c, then settle the low pair
  assign ab_lo_s = (a > b) ? b : a;
  assign ab_hi_s = (a > b) ? a : b;
  assign hi      = (ab_hi_s > c) ? ab_hi_s : c;
  assign bc_lo_s = (ab_hi_s > c) ? c : ab_hi_s;
  assign lo      = (ab_lo_s > bc_lo_s) ? bc_lo_s : ab_lo_s;
  assign mid     = (ab_lo_s > bc_lo_s) ? ab_lo_s : bc_lo_s;

endmodule : sort3

// File: rtl/median9_sort.sv
// median9_sort: pipelined 3x3 median filter, one window per clock, latency 3.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears every stage and pixel_out
//   bus : median9_sort_if.slave (window in, median out, optional valid pair)
// Optional feature macro: MEDIAN9_VALID_EN adds in_valid/out_valid tracking.
// Stage 1 sorts each row, stage 2 sorts each column of the row-sorted grid,
// stage 3 takes median3 of the anti-diagonal, which is the window median.
module median9_sort #(
  parameter int DATA_W = median9_pkg::DATA_W
) (
  input logic          clk,
  input logic          rst,
  median9_sort_if.slave bus
);

  import median9_pkg::*;

  logic [DATA_W-1:0] row_in_s [3][3];   // [row][position]
  logic [DATA_W-1:0] row_s    [3][3];   // [row][L/M/H]
  logic [DATA_W-1:0] s1_r     [3][3];
  logic [DATA_W-1:0] col_s    [3][3];   // [rank][column]
  logic [DATA_W-1:0] s2_r     [3][3];
  logic [DATA_W-1:0] med_s;
  logic [DATA_W-1:0] diag_lo_unused;
  logic [DATA_W-1:0] diag_hi_unused;
  logic [DATA_W-1:0] pixel_out_r;

  assign row_in_s[0][0] = bus.pixel_in0;
  assign row_in_s[0][1] = bus.pixel_in1;
  assign row_in_s[0][2] = bus.pixel_in2;
  assign row_in_s[1][0] = bus.pixel_in3;
  assign row_in_s[1][1] = bus.pixel_in4;
  assign row_in_s[1][2] = bus.pixel_in5;
  assign row_in_s[2][0] = bus.pixel_in6;
  assign row_in_s[2][1] = bus.pixel_in7;
  assign row_in_s[2][2] = bus.pixel_in8;

  for (genvar row = 0; row < 3; row++) begin : g_row
    sort3 #(.DATA_W(DATA_W)) u_row_sort (
      .a  (row_in_s[row][0]),
      .b  (row_in_s[row][1]),
      .c  (row_in_s[row][2]),
      .lo (row_s[row][0]),
      .mid(row_s[row][1]),
      .hi (row_s[row][2])
    );
  end

  for (genvar col = 0; col < 3; col++) begin : g_col
    sort3 #(.DATA_W(DATA_W)) u_col_sort (
      .a  (s1_r[0][col]),
      .b  (s1_r[1][col]),
      .c  (s1_r[2][col]),
      .lo (col_s[0][col]),
      .mid(col_s[1][col]),
      .hi (col_s[2][col])
    );
  end

  // after row and column sorting the median lies on the anti-diagonal
  sort3 #(.DATA_W(DATA_W)) u_diag_sort (
    .a  (s2_r[0][2]),
    .b  (s2_r[1][1]),
    .c  (s2_r[2][0]),
    .lo (diag_lo_unused),
    .mid(med_s),
    .hi (diag_hi_unused)
  );

  // three pipeline stages: row-sorted grid, column-sorted grid, median
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          s1_r[i][j] <= '0;
          s2_r[i][j] <= '0;
        end
      end
      pixel_out_r <= '0;
    end else begin
      s1_r        <= row_s;
      s2_r        <= col_s;
      pixel_out_r <= med_s;
    end
  end

  assign bus.pixel_out = pixel_out_r;

`ifdef MEDIAN9_VALID_EN
  logic [MEDIAN9_LATENCY-1:0] valid_r;

  // valid flag shifted alongside the data stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
    end else begin
      valid_r <= {valid_r[MEDIAN9_LATENCY-2:0], bus.in_valid};
    end
  end

  assign bus.out_valid = valid_r[MEDIAN9_LATENCY-1];
`endif

endmodule : median9_sort

// File: tb/tb_median9_sort.sv
// tb_median9_sort: self-checking bench for median9_sort.
// Reference: median of nine is the smallest window value v with at least five
// window values <= v; expected output after edge n is the median of the window
// sampled at edge n-2 (counting edges from reset release), else 0.
module tb_median9_sort;

  import median9_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  median9_sort_if #(.DATA_W(DATA_W)) bus ();

  median9_sort #(.DATA_W(DATA_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int     pass_cnt = 0;
  int     total    = 0;
  pixel_t hist[$];
  bit     vhist[$];
  int     n_edges  = 0;
  pixel_t w[9];

  function automatic pixel_t median_of(input pixel_t v[9]);
    pixel_t best;
    bit     found;
    best  = '1;
    found = 1'b0;
    for (int i = 0; i < 9; i++) begin
      int cnt;
      cnt = 0;
      for (int j = 0; j < 9; j++) if (v[j] <= v[i]) cnt++;
      if (cnt >= 5 && (!found || v[i] < best)) begin
        best  = v[i];
        found = 1'b1;
      end
    end
    return best;
  endfunction

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic drive(input pixel_t v[9], input bit vld);
    bus.pixel_in0 = v[0]; bus.pixel_in1 = v[1]; bus.pixel_in2 = v[2];
    bus.pixel_in3 = v[3]; bus.pixel_in4 = v[4]; bus.pixel_in5 = v[5];
    bus.pixel_in6 = v[6]; bus.pixel_in7 = v[7]; bus.pixel_in8 = v[8];
`ifdef MEDIAN9_VALID_EN
    bus.in_valid = vld;
`else
    if (vld) begin end
`endif
  endtask

  task automatic reset_model();
    hist.delete();
    vhist.delete();
    n_edges = 0;
  endtask

  // present one window for one edge, then check the output at the falling edge
  task automatic cycle(input string tag, input pixel_t v[9], input bit vld);
    pixel_t exp;
    bit     vexp;
    drive(v, vld);
    @(posedge clk);
    hist.push_back(median_of(v));
    vhist.push_back(vld);
    n_edges++;
    @(negedge clk);
    exp  = (n_edges >= 3) ? hist[n_edges-3] : '0;
    vexp = (n_edges >= 3) ? vhist[n_edges-3] : 1'b0;
    check(tag, bus.pixel_out, exp);
`ifdef MEDIAN9_VALID_EN
    check_bit({tag, "_valid"}, bus.out_valid, vexp);
`else
    if (vexp) begin end
`endif
  endtask

  initial begin
    rst = 1'b1;
    w = '{8'd1, 8'd9, 8'd2, 8'd7, 8'd6, 8'd4, 8'd6, 8'd2, 8'd2};
    drive(w, 1'b1);
    #2;
    check("reset_out", bus.pixel_out, 8'd0);
    #5;
    rst = 1'b0;   // t = 7 ns
    reset_model();

    // basic window: 0, 0, then 4 from the 3rd edge after release
    for (int k = 0; k < 5; k++) cycle("basic", w, 1'b1);

    // extremes
    w = '{9{8'd0}};
    cycle("all_zero", w, 1'b1);
    w = '{9{8'd255}};
    for (int k = 0; k < 4; k++) cycle("all_max", w, 1'b1);

    // back-to-back, with a valid pattern 1,0,1
    w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    cycle("b2b_up", w, 1'b1);
    w = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    cycle("b2b_down", w, 1'b0);
    w = '{8'd5, 8'd5, 8'd5, 8'd1, 8'd1, 8'd1, 8'd9, 8'd9, 8'd9};
    cycle("b2b_rows", w, 1'b1);

    // duplicates
    w = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8};
    cycle("dup_8", w, 1'b1);
    w = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd2, 8'd2, 8'd2, 8'd2};
    cycle("dup_7", w, 1'b1);

    // settle on 4, then reset mid-stream
    w = '{8'd1, 8'd9, 8'd2, 8'd7, 8'd6, 8'd4, 8'd6, 8'd2, 8'd2};
    for (int k = 0; k < 4; k++) cycle("pre_rst", w, 1'b1);
    check("pre_rst_is4", bus.pixel_out, 8'd4);
    rst = 1'b1;
    #1;
    check("async_rst", bus.pixel_out, 8'd0);
`ifdef MEDIAN9_VALID_EN
    check_bit("async_rst_valid", bus.out_valid, 1'b0);
`endif
    @(posedge clk);
    @(negedge clk);
    check("held_rst", bus.pixel_out, 8'd0);
    rst = 1'b0;
    reset_model();
    w = '{8'd200, 8'd10, 8'd50, 8'd90, 8'd120, 8'd30, 8'd70, 8'd250, 8'd60};
    for (int k = 0; k < 4; k++) cycle("post_rst", w, 1'b1);

    // randomized windows, biased toward the extremes
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 9; i++) begin
        if ($urandom_range(0, 3) == 0)
          w[i] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
        else
          w[i] = pixel_t'($urandom_range(0, 255));
      end
      cycle("random", w, bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule : tb_median9_sort
